// File: rtl/lcd_text_frame_driver.sv
// HD44780-class character-LCD driver: power-on init, then continuous ROWS x COLS frame refresh
// from a shadow buffer updated by req/ack. Define LCD_CLR_HOLD_EN to add idle slots after clear.
module lcd_text_frame_driver #(
  parameter int unsigned COLS      = 16,
  parameter int unsigned ROWS      = 2,
  parameter int unsigned SLOT_CYC  = 2001,
  parameter int unsigned EN_ON     = 201,
  parameter int unsigned EN_OFF    = 1801,
  parameter int unsigned CLR_SLOTS = 8
) (
  input  logic                     LCDCLK,
  input  logic                     PRESETn,
  input  logic [8*COLS*ROWS-1:0]   data,
  input  logic                     upd_req,
  output logic                     upd_ack,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     LCD_RS,
  output logic                     LCD_RW,
  output logic                     LCD_EN,
  output logic [7:0]               LCD_DATA
);

  localparam int unsigned W    = 8 * COLS * ROWS;
  localparam int unsigned CntW = $clog2(SLOT_CYC);
  localparam int unsigned ColW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned RowW = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [CntW-1:0] CntMax = CntW'(SLOT_CYC - 1);
  localparam logic [CntW-1:0] EnOn   = CntW'(EN_ON);
  localparam logic [CntW-1:0] EnOff  = CntW'(EN_OFF);
  localparam logic [ColW-1:0] ColMax = ColW'(COLS - 1);
  localparam logic [RowW-1:0] RowMax = RowW'(ROWS - 1);

  localparam logic [1:0] StInit = 2'd0;
  localparam logic [1:0] StClrw = 2'd1;
  localparam logic [1:0] StAddr = 2'd2;
  localparam logic [1:0] StChar = 2'd3;

  function automatic logic [7:0] init_byte(input logic [2:0] i);
    case (i)
      3'd0:    init_byte = 8'h38;
      3'd1:    init_byte = 8'h0E;
      3'd2:    init_byte = 8'h06;
      3'd3:    init_byte = 8'h02;
      default: init_byte = 8'h01;
    endcase
  endfunction

  function automatic logic [7:0] row_base(input logic [1:0] r);
    case (r)
      2'd0:    row_base = 8'h00;
      2'd1:    row_base = 8'h40;
      2'd2:    row_base = 8'h14;
      default: row_base = 8'h54;
    endcase
  endfunction

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [RowW-1:0] row_q, row_d;
  logic [ColW-1:0] col_q, col_d;
  logic            idle_q, idle_d;
  logic            last_q, last_d;
  logic            busy_q, busy_d;
  logic            ack_q, ack_d;
  logic            fd_q, fd_d;
  logic            rs_q, rs_d;
  logic            en_q, en_d;
  logic [7:0]      data_q, data_d;
  logic [W-1:0]    shadow_q;
  logic            shadow_ld;
  int unsigned     char_idx;

`ifdef LCD_CLR_HOLD_EN
  localparam int unsigned ClrW = (CLR_SLOTS > 1) ? $clog2(CLR_SLOTS) : 1;
  localparam logic [ClrW-1:0] ClrMax = ClrW'(CLR_SLOTS - 1);
  logic [ClrW-1:0] clr_q, clr_d;
`endif

  always_comb begin
    cnt_d     = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
    state_d   = state_q;
    idx_d     = idx_q;
    row_d     = row_q;
    col_d     = col_q;
    idle_d    = idle_q;
    last_d    = last_q;
    busy_d    = busy_q;
    ack_d     = 1'b0;
    rs_d      = rs_q;
    data_d    = data_q;
    shadow_ld = 1'b0;
    char_idx  = 32'(row_q) * COLS + 32'(col_q);
`ifdef LCD_CLR_HOLD_EN
    clr_d     = clr_q;
`endif
    if (cnt_q == '0) begin
      idle_d = 1'b0;
      last_d = 1'b0;
      unique case (state_q)
        StInit: begin
          data_d = init_byte(idx_q);
          rs_d   = 1'b0;
          if (idx_q == 3'd4) begin
            idx_d = '0;
`ifdef LCD_CLR_HOLD_EN
            clr_d   = '0;
            state_d = StClrw;
`else
            state_d = StAddr;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        StClrw: begin
`ifdef LCD_CLR_HOLD_EN
          idle_d = 1'b1;
          if (clr_q == ClrMax) state_d = StAddr;
          else clr_d = clr_q + 1'b1;
`else
          state_d = StAddr;
`endif
        end
        StAddr: begin
          data_d  = 8'h80 | row_base(2'(row_q));
          rs_d    = 1'b0;
          col_d   = '0;
          state_d = StChar;
          // Frame boundary: the very first one loads the shadow even without a request.
          if (row_q == '0) begin
            busy_d    = 1'b0;
            shadow_ld = busy_q | upd_req;
            ack_d     = upd_req;
          end
        end
        StChar: begin
          data_d = shadow_q[W - 1 - 8 * char_idx -: 8];
          rs_d   = 1'b1;
          if (col_q == ColMax) begin
            state_d = StAddr;
            last_d  = (row_q == RowMax);
            row_d   = (row_q == RowMax) ? '0 : row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
        default: state_d = StInit;
      endcase
    end
    en_d = (cnt_d >= EnOn) && (cnt_d < EnOff) && !idle_d;
    fd_d = last_d && (cnt_d == CntMax);
  end

  always_ff @(posedge LCDCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt_q   <= '0;
      state_q <= StInit;
      idx_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      idle_q  <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b1;
      ack_q   <= 1'b0;
      fd_q    <= 1'b0;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      data_q  <= '0;
`ifdef LCD_CLR_HOLD_EN
      clr_q   <= '0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      col_q   <= col_d;
      idle_q  <= idle_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      fd_q    <= fd_d;
      rs_q    <= rs_d;
      en_q    <= en_d;
      data_q  <= data_d;
`ifdef LCD_CLR_HOLD_EN
      clr_q   <= clr_d;
`endif
    end
  end

  always_ff @(posedge LCDCLK) begin
    if (shadow_ld) shadow_q <= data;
  end

  assign upd_ack    = ack_q;
  assign busy       = busy_q;
  assign frame_done = fd_q;
  assign LCD_RS     = rs_q;
  assign LCD_RW     = 1'b0;
  assign LCD_EN     = en_q;
  assign LCD_DATA   = data_q;

endmodule

// File: tb/tb_lcd_text_frame_driver.sv
// Directed bench for lcd_text_frame_driver: init, frame order, 4-row addressing, handshake,
// optional clear hold (LCD_CLR_HOLD_EN) and mid-frame reset.
module tb_lcd_text_frame_driver;

  localparam int S = 20;
`ifdef LCD_CLR_HOLD_EN
  localparam int ClrSlots = 3;
`endif

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [255:0] data0;
  logic         req0 = 1'b0;
  logic         ack0, busy0, fd0, rs0, rw0, en0;
  logic [7:0]   d0;
  logic [127:0] data1;
  logic         req1 = 1'b0;
  logic         ack1, busy1, fd1, rs1, rw1, en1;
  logic [7:0]   d1;

  logic [255:0] text1, text2, text3, text4;
  int checks = 0;
  int failures = 0;
  int fd_seen, ack_seen, en_hi, en_first;
  logic fd_pre;

  always #5 clk = ~clk;

  lcd_text_frame_driver #(
    .COLS(16), .ROWS(2), .SLOT_CYC(S), .EN_ON(3), .EN_OFF(15), .CLR_SLOTS(3)
  ) dut0 (
    .LCDCLK(clk), .PRESETn(rstn), .data(data0), .upd_req(req0), .upd_ack(ack0), .busy(busy0),
    .frame_done(fd0), .LCD_RS(rs0), .LCD_RW(rw0), .LCD_EN(en0), .LCD_DATA(d0)
  );

  lcd_text_frame_driver #(
    .COLS(4), .ROWS(4), .SLOT_CYC(S), .EN_ON(3), .EN_OFF(15), .CLR_SLOTS(3)
  ) dut1 (
    .LCDCLK(clk), .PRESETn(rstn), .data(data1), .upd_req(req1), .upd_ack(ack1), .busy(busy1),
    .frame_done(fd1), .LCD_RS(rs1), .LCD_RW(rw1), .LCD_EN(en1), .LCD_DATA(d1)
  );

  function automatic logic [7:0] byte_of(input logic [255:0] t, input int i);
    logic [255:0] tmp;
    tmp = t;
    return tmp[255 - 8 * i -: 8];
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // From one launch sample (slot count 1) to the next, recording dut0 slot activity.
  task automatic next_launch;
    fd_seen = 0; ack_seen = 0; en_hi = 0; en_first = -1;
    for (int k = 1; k <= S; k++) begin
      if (en0) begin
        en_hi++;
        if (en_first < 0) en_first = k % S;
      end
      if (k == S - 1) fd_pre = fd0;
      if (fd0) fd_seen++;
      if (k >= 2 && ack0) ack_seen++;
      step;
    end
  endtask

  task automatic run_frame(input logic [255:0] txt, input int req_at, input logic [255:0] req_txt,
                           input int chg_at, input logic [255:0] chg_txt, input int stop_at);
    int fd_tot = 0;
    int ack_tot = 0;
    for (int r = 0; r < 2; r++) begin
      checks++;
      if (d0 !== (r == 0 ? 8'h80 : 8'hC0) || rs0 !== 1'b0) begin
        failures++;
        $display("FAIL addr_cmd row=%0d got data=%h rs=%b exp data=%h rs=0", r, d0, rs0,
                 (r == 0 ? 8'h80 : 8'hC0));
      end
      next_launch; fd_tot += fd_seen; ack_tot += ack_seen;
      for (int c = 0; c < 16; c++) begin
        int idx = r * 16 + c;
        checks++;
        if (d0 !== byte_of(txt, idx) || rs0 !== 1'b1) begin
          failures++;
          $display("FAIL char idx=%0d got data=%h rs=%b exp data=%h rs=1", idx, d0, rs0,
                   byte_of(txt, idx));
        end
        if (idx == req_at) begin data0 = req_txt; req0 = 1'b1; end
        if (idx == chg_at) data0 = chg_txt;
        if (idx == stop_at) return;
        next_launch; fd_tot += fd_seen; ack_tot += ack_seen;
      end
    end
    checks++;
    if (fd_tot != 1 || fd_pre !== 1'b1) begin
      failures++;
      $display("FAIL frame_done got pulses=%0d last_cycle=%b exp pulses=1 last_cycle=1",
               fd_tot, fd_pre);
    end
    checks++;
    if (ack_tot != 0) begin
      failures++;
      $display("FAIL ack_mid_frame got pulses=%0d exp 0", ack_tot);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({d0, rs0, rw0, en0, ack0, fd0, busy0} !== {8'h00, 6'b000001}) begin
      failures++;
      $display("FAIL reset_dut0 got data=%h rs=%b rw=%b en=%b ack=%b fd=%b busy=%b exp zeros busy=1",
               d0, rs0, rw0, en0, ack0, fd0, busy0);
    end
    checks++;
    if ({d1, rs1, rw1, en1, ack1, fd1, busy1} !== {8'h00, 6'b000001}) begin
      failures++;
      $display("FAIL reset_dut1 got data=%h rs=%b rw=%b en=%b ack=%b fd=%b busy=%b exp zeros busy=1",
               d1, rs1, rw1, en1, ack1, fd1, busy1);
    end
  endtask

  task automatic test_init;
    logic [7:0] seq [5] = '{8'h38, 8'h0E, 8'h06, 8'h02, 8'h01};
    @(negedge clk) rstn = 1'b1;
    step;
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (d0 !== seq[j] || rs0 !== 1'b0 || busy0 !== 1'b1) begin
        failures++;
        $display("FAIL init_byte %0d got data=%h rs=%b busy=%b exp data=%h rs=0 busy=1",
                 j, d0, rs0, busy0, seq[j]);
      end
      next_launch;
      checks++;
      if (en_hi != 12 || en_first != 3) begin
        failures++;
        $display("FAIL init_en %0d got width=%0d start=%0d exp width=12 start=3",
                 j, en_hi, en_first);
      end
    end
`ifdef LCD_CLR_HOLD_EN
    for (int c = 0; c < ClrSlots; c++) begin
      next_launch;
      checks++;
      if (en_hi != 0 || d0 !== 8'h01) begin
        failures++;
        $display("FAIL clr_hold %0d got en_cycles=%0d data=%h exp 0 and 01", c, en_hi, d0);
      end
    end
`endif
    checks++;
    if (d0 !== 8'h80 || busy0 !== 1'b0 || ack0 !== 1'b0) begin
      failures++;
      $display("FAIL first_addr got data=%h busy=%b ack=%b exp data=80 busy=0 ack=0",
               d0, busy0, ack0);
    end
  endtask

  task automatic test_frame;
    run_frame(text1, -1, text1, -1, text1, -1);
    checks++;
    if (ack0 !== 1'b0) begin
      failures++;
      $display("FAIL no_req_ack got %b exp 0", ack0);
    end
    run_frame(text1, -1, text1, -1, text1, -1);
  endtask

  task automatic test_handshake;
    run_frame(text1, 5, text2, -1, text1, -1);
    checks++;
    if (ack0 !== 1'b1 || d0 !== 8'h80) begin
      failures++;
      $display("FAIL ack_boundary got ack=%b data=%h exp ack=1 data=80", ack0, d0);
    end
    req0 = 1'b0;
    run_frame(text2, 20, text3, 25, text4, -1);
    checks++;
    if (ack0 !== 1'b1) begin
      failures++;
      $display("FAIL ack_changed_data got %b exp 1", ack0);
    end
    req0 = 1'b0;
    run_frame(text4, -1, text1, -1, text1, -1);
    checks++;
    if (ack0 !== 1'b0) begin
      failures++;
      $display("FAIL ack_idle_boundary got %b exp 0", ack0);
    end
  endtask

  task automatic test_reset_mid_frame;
    run_frame(text4, -1, text1, -1, text1, 16 + 7);
    repeat (4) step;
    rstn = 1'b0;
    #1;
    checks++;
    if ({d0, rs0, rw0, en0, ack0, fd0, busy0} !== {8'h00, 6'b000001}) begin
      failures++;
      $display("FAIL mid_reset got data=%h rs=%b rw=%b en=%b ack=%b fd=%b busy=%b exp zeros busy=1",
               d0, rs0, rw0, en0, ack0, fd0, busy0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    step;
    checks++;
    if (d0 !== 8'h38 || rs0 !== 1'b0 || busy0 !== 1'b1 || d1 !== 8'h38) begin
      failures++;
      $display("FAIL restart_init got data0=%h rs=%b busy=%b data1=%h exp 38 0 1 38",
               d0, rs0, busy0, d1);
    end
  endtask

  task automatic test_four_row;
    logic [7:0] cmd [4] = '{8'h80, 8'hC0, 8'h94, 8'hD4};
    int n_init = 5;
`ifdef LCD_CLR_HOLD_EN
    n_init = 5 + ClrSlots;
`endif
    for (int j = 0; j < n_init; j++) next_launch;
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (d1 !== cmd[r] || rs1 !== 1'b0) begin
        failures++;
        $display("FAIL row4_cmd %0d got data=%h rs=%b exp data=%h rs=0", r, d1, rs1, cmd[r]);
      end
      next_launch;
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (d1 !== 8'(8'h40 + r * 4 + c) || rs1 !== 1'b1) begin
          failures++;
          $display("FAIL row4_char r=%0d c=%0d got data=%h rs=%b exp data=%h rs=1", r, c, d1,
                   rs1, 8'(8'h40 + r * 4 + c));
        end
        next_launch;
      end
    end
    checks++;
    if (d1 !== 8'h80) begin
      failures++;
      $display("FAIL row4_wrap got data=%h exp 80", d1);
    end
  endtask

  initial begin
    text1 = {"ABCDEFGHIJKLMNOP", "abcdefghijklmnop"};
    text2 = {"Hello, world!   ", "0123456789abcdef"};
    text3 = {"XXXXXXXXXXXXXXXX", "YYYYYYYYYYYYYYYY"};
    text4 = {"new text line 1 ", "new text line 2 "};
    data0 = text1;
    for (int k = 0; k < 16; k++) data1[127 - 8 * k -: 8] = 8'(8'h40 + k);
    test_reset;
    test_init;
    test_frame;
    test_handshake;
    test_reset_mid_frame;
    test_four_row;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
